// File: rtl/sdram_bridge_pkg.sv
// sdram_bridge_pkg
// Shared types and helpers for the APB-to-SDRAM-controller bridge:
//   core_state_t  - request FSM states towards the SDRAM controller core
//   wbuf_entry_t  - one posted-write entry {addr, data, strb}
//   chip_selected - per-chip select decode used to build sdram_sel
package sdram_bridge_pkg;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_REQ  = 2'd1,
    C_ACK  = 2'd2
  } core_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wbuf_entry_t;

  // Chip 'chip' is selected when a read/write command targets it, or
  // unconditionally for any other command (activate/refresh/precharge are
  // broadcast to every chip on the word-extension bus).
  function automatic logic chip_selected(input logic       rw_cmd,
                                         input logic [1:0] idx,
                                         input int         chip);
    return !rw_cmd || (idx == 2'(chip));
  endfunction

endpackage

// File: rtl/sdram_wbuf.sv
// sdram_wbuf
// Synchronous FIFO holding posted APB writes until the core accepts them.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clock, reset    - clock, synchronous active-high reset (empties FIFO)
//   push_i          - write push_data_i (honoured when not full, or when a
//                     pop frees a slot in the same cycle)
//   push_data_i     - entry to store
//   pop_i           - discard head entry (ignored when empty)
//   head_o          - oldest entry
//   full_o, empty_o - occupancy flags
module sdram_wbuf
  import sdram_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  wbuf_entry_t push_data_i,
  input  logic        pop_i,
  output wbuf_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);

  wbuf_entry_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs when full.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset drops every buffered write.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/sdram_apb_bridge.sv
// sdram_apb_bridge
// APB slave that forwards accesses in the SDRAM window to the SDRAM
// controller core. Writes are posted into a small FIFO and answered with
// zero wait states; reads wait for the FIFO to drain (strict ordering) and
// answer one cycle after the core ack. A write error reported by the core
// is remembered and returned on the next completing APB transfer.
// Ports:
//   clock, reset                      - clock, synchronous active-high reset
//   in_p*                             - APB request / response (pprot unused)
//   core_wr/core_rd/core_addr/wdata   - request to the core, held until accept
//   core_accept, core_ack, core_error,
//   core_rdata                        - core handshake and completion
//   sdram_cs/ras/cas                  - SDRAM command pins (observed only)
//   sdram_sel                         - per-chip select on the extension bus
module sdram_apb_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int          NUM_CHIPS  = 2,
  parameter int          CHIP_LSB   = 26,
  parameter int          WBUF_DEPTH = 4,
  parameter logic [31:0] BASE       = 32'hA000_0000,
  parameter logic [31:0] ADDR_MASK  = 32'h1FFF_FFFF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          in_paddr,
  input  logic                 in_psel,
  input  logic                 in_penable,
  input  logic [2:0]           in_pprot,
  input  logic                 in_pwrite,
  input  logic [31:0]          in_pwdata,
  input  logic [3:0]           in_pstrb,
  output logic                 in_pready,
  output logic [31:0]          in_prdata,
  output logic                 in_pslverr,
  output logic [3:0]           core_wr,
  output logic                 core_rd,
  output logic [31:0]          core_addr,
  output logic [31:0]          core_wdata,
  input  logic                 core_accept,
  input  logic                 core_ack,
  input  logic                 core_error,
  input  logic [31:0]          core_rdata,
  input  logic                 sdram_cs,
  input  logic                 sdram_ras,
  input  logic                 sdram_cas,
  output logic [NUM_CHIPS-1:0] sdram_sel
);

  logic        unused_pprot;
  logic        access;
  logic        in_win;
  logic        win_err;
  logic        wr_ok;
  logic        rd_want;
  logic        pop;
  logic        ack_evt;
  logic        rd_resp;
  logic        complete;
  wbuf_entry_t push_entry;
  wbuf_entry_t head;
  logic        wb_full;
  logic        wb_empty;

  core_state_t state_q, state_d;
  logic        load_rd, load_head, load_push;

  logic [3:0]  core_wr_q;
  logic        core_rd_q;
  logic [31:0] core_addr_q;
  logic [31:0] core_wdata_q;
  logic        is_rd_q;

  logic        rd_busy_q;
  logic        rd_resp_q;
  logic        rd_err_q;
  logic [31:0] rd_data_q;
  logic        wr_err_q;

  assign unused_pprot = ^in_pprot;

  assign access   = in_psel & in_penable & ~reset;
  assign in_win   = ((in_paddr & ~ADDR_MASK) == BASE);
  assign win_err  = access & ~in_win;
  assign pop      = (state_q == C_REQ) & core_accept & ~is_rd_q;
  assign wr_ok    = access & in_win & in_pwrite & (~wb_full | pop);
  // A read is requested only once: while it is in flight or being answered
  // the still-held APB access phase must not launch another one.
  assign rd_want  = access & in_win & ~in_pwrite & ~rd_busy_q & ~rd_resp_q;
  assign ack_evt  = ((state_q == C_ACK) & core_ack) |
                    ((state_q == C_REQ) & core_accept & core_ack);
  assign rd_resp  = rd_resp_q & ~reset;
  assign complete = win_err | wr_ok | rd_resp;

  assign push_entry = '{addr: in_paddr, data: in_pwdata, strb: in_pstrb};

  assign in_pready  = complete;
  assign in_prdata  = rd_resp ? rd_data_q : 32'd0;
  assign in_pslverr = win_err | (complete & wr_err_q) | (rd_resp & rd_err_q);

  assign core_wr    = core_wr_q;
  assign core_rd    = core_rd_q;
  assign core_addr  = core_addr_q;
  assign core_wdata = core_wdata_q;

  sdram_wbuf #(
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clock      (clock),
    .reset      (reset),
    .push_i     (wr_ok),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (wb_full),
    .empty_o    (wb_empty)
  );

  // Core FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= C_IDLE;
    else       state_q <= state_d;
  end

  // Core FSM next state. Reads go first only when the buffer is empty, so
  // every earlier posted write reaches the core before the read. A write
  // arriving while idle and empty is issued straight from the APB bus so
  // the request appears one cycle after the access.
  always_comb begin
    state_d   = state_q;
    load_rd   = 1'b0;
    load_head = 1'b0;
    load_push = 1'b0;
    unique case (state_q)
      C_IDLE: begin
        if (rd_want && wb_empty) begin
          load_rd = 1'b1;
          state_d = C_REQ;
        end else if (!wb_empty) begin
          load_head = 1'b1;
          state_d   = C_REQ;
        end else if (wr_ok) begin
          load_push = 1'b1;
          state_d   = C_REQ;
        end
      end
      C_REQ: begin
        if (core_accept) state_d = core_ack ? C_IDLE : C_ACK;
      end
      C_ACK: begin
        if (core_ack) state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Request registers. Address and data stay put after accept so the chip
  // select can still be decoded while the core runs the command.
  always_ff @(posedge clock) begin
    if (reset) begin
      core_wr_q    <= '0;
      core_rd_q    <= 1'b0;
      core_addr_q  <= '0;
      core_wdata_q <= '0;
      is_rd_q      <= 1'b0;
    end else if (load_rd) begin
      core_wr_q    <= '0;
      core_rd_q    <= 1'b1;
      core_addr_q  <= in_paddr;
      core_wdata_q <= '0;
      is_rd_q      <= 1'b1;
    end else if (load_head) begin
      core_wr_q    <= head.strb;
      core_rd_q    <= 1'b0;
      core_addr_q  <= head.addr;
      core_wdata_q <= head.data;
      is_rd_q      <= 1'b0;
    end else if (load_push) begin
      core_wr_q    <= push_entry.strb;
      core_rd_q    <= 1'b0;
      core_addr_q  <= push_entry.addr;
      core_wdata_q <= push_entry.data;
      is_rd_q      <= 1'b0;
    end else if ((state_q == C_REQ) && core_accept) begin
      core_wr_q <= '0;
      core_rd_q <= 1'b0;
    end
  end

  // Read completion and sticky write-error tracking. A new error wins over
  // a clear in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_busy_q <= 1'b0;
      rd_resp_q <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      if (load_rd)                rd_busy_q <= 1'b1;
      else if (ack_evt & is_rd_q) rd_busy_q <= 1'b0;
      rd_resp_q <= ack_evt & is_rd_q;
      if (ack_evt & is_rd_q) begin
        rd_data_q <= core_rdata;
        rd_err_q  <= core_error;
      end
      wr_err_q <= (ack_evt & ~is_rd_q & core_error) | (wr_err_q & ~complete);
    end
  end

  // Chip select on the word-extension bus, decoded from the in-flight
  // request address rather than the live APB address.
  generate
    if (NUM_CHIPS == 1) begin : g_single
      logic unused_pins;
      assign unused_pins = ^{sdram_cs, sdram_ras, sdram_cas};
      assign sdram_sel   = 1'b1;
    end else begin : g_multi
      localparam int CW = $clog2(NUM_CHIPS);
      logic       rw_cmd;
      logic [1:0] chip_idx;
      assign rw_cmd   = ~sdram_cs & sdram_ras & ~sdram_cas;
      assign chip_idx = 2'(core_addr_q[CHIP_LSB +: CW]);
      for (genvar c = 0; c < NUM_CHIPS; c++) begin : g_chip
        assign sdram_sel[c] = chip_selected(rw_cmd, chip_idx, c);
      end
    end
  endgenerate

endmodule

// File: tb/tb_sdram_apb_bridge.sv
// tb_sdram_apb_bridge
// Directed bench for sdram_apb_bridge with default parameters
// (NUM_CHIPS=2, WBUF_DEPTH=4, window 0xA000_0000 / mask 0x1FFF_FFFF).
// The bench plays both the APB master and the SDRAM controller core.
module tb_sdram_apb_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic [2:0]  in_pprot;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic [3:0]  core_wr;
  logic        core_rd;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_accept;
  logic        core_ack;
  logic        core_error;
  logic [31:0] core_rdata;
  logic        sdram_cs;
  logic        sdram_ras;
  logic        sdram_cas;
  logic [1:0]  sdram_sel;

  int assertCount = 0;
  int failCount   = 0;

  sdram_apb_bridge dut (
    .clock      (clock),
    .reset      (reset),
    .in_paddr   (in_paddr),
    .in_psel    (in_psel),
    .in_penable (in_penable),
    .in_pprot   (in_pprot),
    .in_pwrite  (in_pwrite),
    .in_pwdata  (in_pwdata),
    .in_pstrb   (in_pstrb),
    .in_pready  (in_pready),
    .in_prdata  (in_prdata),
    .in_pslverr (in_pslverr),
    .core_wr    (core_wr),
    .core_rd    (core_rd),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_accept(core_accept),
    .core_ack   (core_ack),
    .core_error (core_error),
    .core_rdata (core_rdata),
    .sdram_cs   (sdram_cs),
    .sdram_ras  (sdram_ras),
    .sdram_cas  (sdram_cas),
    .sdram_sel  (sdram_sel)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Setup phase on one falling edge, access phase on the next; returns
  // just after the access phase starts so combinational answers are valid.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    @(negedge clock);
    in_psel    = 1'b1;
    in_penable = 1'b0;
    in_pwrite  = wr;
    in_paddr   = addr;
    in_pwdata  = data;
    in_pstrb   = strb;
    @(negedge clock);
    in_penable = 1'b1;
    #1;
  endtask

  task automatic apbRelease();
    @(negedge clock);
    in_psel    = 1'b0;
    in_penable = 1'b0;
    #1;
  endtask

  task automatic waitCoreReq(input string tag, input logic wantRead);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      #1;
      if (wantRead ? core_rd : (core_wr != 4'h0)) seen = 1'b1;
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  // Core side of one buffered write: accept and ack in the same cycle.
  task automatic serveWrite(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic err);
    waitCoreReq({tag, "_req"}, 1'b0);
    checkOutput({tag, "_addr"}, core_addr, addr);
    checkOutput({tag, "_data"}, core_wdata, data);
    core_accept = 1'b1;
    core_ack    = 1'b1;
    core_error  = err;
    @(negedge clock);
    core_accept = 1'b0;
    core_ack    = 1'b0;
    core_error  = 1'b0;
  endtask

  // Whole in-window read: core answers with accept and ack together.
  task automatic doRead(input string tag, input logic [31:0] addr,
                        input logic [31:0] rdata, input logic expErr);
    applyStimulus(1'b0, addr, 32'd0, 4'h0);
    waitCoreReq({tag, "_req"}, 1'b1);
    checkOutput({tag, "_addr"}, core_addr, addr);
    core_accept = 1'b1;
    core_ack    = 1'b1;
    core_rdata  = rdata;
    @(negedge clock);
    core_accept = 1'b0;
    core_ack    = 1'b0;
    #1;
    checkOutput({tag, "_pready"}, {31'd0, in_pready}, 32'd1);
    checkOutput({tag, "_prdata"}, in_prdata, rdata);
    checkOutput({tag, "_pslverr"}, {31'd0, in_pslverr}, {31'd0, expErr});
    apbRelease();
  endtask

  initial begin
    reset = 1'b1;
    in_paddr = '0; in_psel = 1'b0; in_penable = 1'b0; in_pprot = '0;
    in_pwrite = 1'b0; in_pwdata = '0; in_pstrb = '0;
    core_accept = 1'b0; core_ack = 1'b0; core_error = 1'b0; core_rdata = '0;
    sdram_cs = 1'b1; sdram_ras = 1'b1; sdram_cas = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_pready", {31'd0, in_pready}, 32'd0);
    checkOutput("rst_prdata", in_prdata, 32'd0);
    checkOutput("rst_pslverr", {31'd0, in_pslverr}, 32'd0);
    checkOutput("rst_core_wr", {28'd0, core_wr}, 32'd0);
    checkOutput("rst_core_rd", {31'd0, core_rd}, 32'd0);
    checkOutput("rst_core_addr", core_addr, 32'd0);
    checkOutput("rst_core_wdata", core_wdata, 32'd0);
    checkOutput("rst_sel", {30'd0, sdram_sel}, 32'd3);

    // Single posted write, request one cycle after the access
    applyStimulus(1'b1, 32'hA000_0010, 32'hDEAD_BEEF, 4'hF);
    checkOutput("wr1_pready", {31'd0, in_pready}, 32'd1);
    checkOutput("wr1_pslverr", {31'd0, in_pslverr}, 32'd0);
    apbRelease();
    checkOutput("wr1_core_wr", {28'd0, core_wr}, 32'h0000_000F);
    checkOutput("wr1_core_addr", core_addr, 32'hA000_0010);
    checkOutput("wr1_core_wdata", core_wdata, 32'hDEAD_BEEF);
    checkOutput("wr1_pready_low", {31'd0, in_pready}, 32'd0);
    sdram_cs = 1'b0; sdram_ras = 1'b1; sdram_cas = 1'b0;
    #1;
    checkOutput("wr1_sel_chip0", {30'd0, sdram_sel}, 32'd1);
    sdram_cs = 1'b1; sdram_cas = 1'b1;
    core_accept = 1'b1;
    core_ack    = 1'b1;
    @(negedge clock);
    core_accept = 1'b0;
    core_ack    = 1'b0;
    #1;
    checkOutput("wr1_core_wr_clr", {28'd0, core_wr}, 32'd0);

    // Five writes into a four-entry buffer with the core stalled
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hA000_0100 + 32'(4 * i), 32'(i + 1), 4'hF);
      checkOutput($sformatf("burst%0d_pready", i), {31'd0, in_pready}, 32'd1);
    end
    applyStimulus(1'b1, 32'hA000_0110, 32'd5, 4'hF);
    checkOutput("burst4_stall0", {31'd0, in_pready}, 32'd0);
    @(negedge clock);
    #1;
    checkOutput("burst4_stall1", {31'd0, in_pready}, 32'd0);
    checkOutput("burst4_head_addr", core_addr, 32'hA000_0100);
    core_accept = 1'b1;
    #1;
    checkOutput("burst4_pready_on_pop", {31'd0, in_pready}, 32'd1);
    @(negedge clock);
    in_psel = 1'b0; in_penable = 1'b0; core_accept = 1'b0;
    #1;
    checkOutput("burst_wr_after_accept", {28'd0, core_wr}, 32'd0);
    core_ack = 1'b1;
    @(negedge clock);
    core_ack = 1'b0;
    for (int i = 1; i < 5; i++) begin
      serveWrite($sformatf("drain%0d", i), 32'hA000_0100 + 32'(4 * i), 32'(i + 1), 1'b0);
    end

    // Write then read of the same address: read waits for the write ack
    applyStimulus(1'b1, 32'hA000_0200, 32'h1234_5678, 4'hF);
    checkOutput("wr2_pready", {31'd0, in_pready}, 32'd1);
    applyStimulus(1'b0, 32'hA000_0200, 32'd0, 4'h0);
    checkOutput("rd2_wait_pready", {31'd0, in_pready}, 32'd0);
    checkOutput("rd2_wait_rd0", {31'd0, core_rd}, 32'd0);
    checkOutput("wr2_core_wr", {28'd0, core_wr}, 32'h0000_000F);
    @(negedge clock);
    #1;
    checkOutput("rd2_wait_rd1", {31'd0, core_rd}, 32'd0);
    core_accept = 1'b1;
    @(negedge clock);
    core_accept = 1'b0;
    #1;
    checkOutput("rd2_wait_rd2", {31'd0, core_rd}, 32'd0);
    @(negedge clock);
    #1;
    checkOutput("rd2_wait_rd3", {31'd0, core_rd}, 32'd0);
    core_ack = 1'b1;
    @(negedge clock);
    core_ack = 1'b0;
    #1;
    checkOutput("rd2_wait_rd4", {31'd0, core_rd}, 32'd0);
    @(negedge clock);
    #1;
    checkOutput("rd2_core_rd", {31'd0, core_rd}, 32'd1);
    checkOutput("rd2_core_addr", core_addr, 32'hA000_0200);
    core_accept = 1'b1;
    @(negedge clock);
    core_accept = 1'b0;
    #1;
    checkOutput("rd2_pready_before_ack", {31'd0, in_pready}, 32'd0);
    checkOutput("rd2_core_rd_clr", {31'd0, core_rd}, 32'd0);
    @(negedge clock);
    core_ack   = 1'b1;
    core_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    core_ack = 1'b0;
    #1;
    checkOutput("rd2_pready", {31'd0, in_pready}, 32'd1);
    checkOutput("rd2_prdata", in_prdata, 32'hCAFE_F00D);
    checkOutput("rd2_pslverr", {31'd0, in_pslverr}, 32'd0);
    in_psel = 1'b0; in_penable = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("rd2_pready_one_cycle", {31'd0, in_pready}, 32'd0);
    checkOutput("rd2_prdata_clr", in_prdata, 32'd0);

    // Out-of-window read: immediate error, no core request
    applyStimulus(1'b0, 32'h8000_0000, 32'd0, 4'h0);
    checkOutput("oow_pready", {31'd0, in_pready}, 32'd1);
    checkOutput("oow_pslverr", {31'd0, in_pslverr}, 32'd1);
    checkOutput("oow_prdata", in_prdata, 32'd0);
    apbRelease();
    checkOutput("oow_no_rd", {31'd0, core_rd}, 32'd0);
    checkOutput("oow_no_wr", {28'd0, core_wr}, 32'd0);

    // Sticky write error reported on the next read, then cleared
    applyStimulus(1'b1, 32'hA000_0300, 32'h0000_00AA, 4'h3);
    checkOutput("werr_pready", {31'd0, in_pready}, 32'd1);
    checkOutput("werr_pslverr", {31'd0, in_pslverr}, 32'd0);
    apbRelease();
    checkOutput("werr_strb", {28'd0, core_wr}, 32'h0000_0003);
    serveWrite("werr", 32'hA000_0300, 32'h0000_00AA, 1'b1);
    doRead("sticky_rd", 32'hA000_0304, 32'h0000_0011, 1'b1);
    doRead("clean_rd", 32'hA000_0308, 32'h0000_0022, 1'b0);

    // Chip select from the in-flight request, not the live APB address
    applyStimulus(1'b0, 32'hA400_0000, 32'd0, 4'h0);
    waitCoreReq("sel_req", 1'b1);
    core_accept = 1'b1;
    @(negedge clock);
    core_accept = 1'b0;
    sdram_cs = 1'b0; sdram_ras = 1'b1; sdram_cas = 1'b0;
    #1;
    checkOutput("sel_rw_chip1", {30'd0, sdram_sel}, 32'd2);
    in_paddr = 32'hA000_0000;
    #1;
    checkOutput("sel_rw_paddr_moved", {30'd0, sdram_sel}, 32'd2);
    sdram_ras = 1'b0;
    #1;
    checkOutput("sel_refresh", {30'd0, sdram_sel}, 32'd3);
    in_paddr = 32'hA400_0000;
    sdram_cs = 1'b1; sdram_ras = 1'b1; sdram_cas = 1'b1;
    core_ack   = 1'b1;
    core_rdata = 32'h0000_0033;
    @(negedge clock);
    core_ack = 1'b0;
    #1;
    checkOutput("sel_rd_pready", {31'd0, in_pready}, 32'd1);
    checkOutput("sel_rd_prdata", in_prdata, 32'h0000_0033);
    apbRelease();

    // Reset mid-operation discards the buffered writes
    applyStimulus(1'b1, 32'hA000_0400, 32'h0000_0055, 4'hF);
    applyStimulus(1'b1, 32'hA000_0404, 32'h0000_0066, 4'hF);
    apbRelease();
    checkOutput("mid_core_wr", {28'd0, core_wr}, 32'h0000_000F);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_core_wr", {28'd0, core_wr}, 32'd0);
    checkOutput("mid_rst_core_addr", core_addr, 32'd0);
    repeat (3) @(negedge clock);
    #1;
    checkOutput("mid_rst_discarded", {28'd0, core_wr}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
